// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// index width and the active-low segment codes (bit6 = g .. bit0 = a).
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_scan_ctrl_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder with a
// blank override for leading-zero suppression.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] seg_s;

  // Nibble to segment pattern, blank wins over the nibble
  always_comb begin
    seg_s = SEG_BLANK;
    if (blank) begin
      seg_s = SEG_BLANK;
    end else begin
      case (nib)
        4'h0:    seg_s = SEG_0;
        4'h1:    seg_s = SEG_1;
        4'h2:    seg_s = SEG_2;
        4'h3:    seg_s = SEG_3;
        4'h4:    seg_s = SEG_4;
        4'h5:    seg_s = SEG_5;
        4'h6:    seg_s = SEG_6;
        4'h7:    seg_s = SEG_7;
        4'h8:    seg_s = SEG_8;
        4'h9:    seg_s = SEG_9;
        4'hA:    seg_s = SEG_A;
        4'hB:    seg_s = SEG_B;
        4'hC:    seg_s = SEG_C;
        4'hD:    seg_s = SEG_D;
        4'hE:    seg_s = SEG_E;
        4'hF:    seg_s = SEG_F;
        default: seg_s = SEG_BLANK;
      endcase
    end
  end

  assign seg = seg_s;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit seven-segment scan controller: load/ack handshake with the new
// value committed only at the frame boundary so a digit never tears.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic        ack,
  output logic        pending,
  output logic        frame_done,
  output logic [6:0]  SevenSegout,
  output logic [3:0]  en
);

  localparam int                DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_r;
  logic [IDX_W-1:0] idx_r;
  logic [15:0]      disp_r;
  logic [15:0]      pval_r;
  logic             pend_r;
  logic             ack_r;
  logic             fd_r;

  logic             tick_s;
  logic             boundary_s;
  logic             commit_s;
  logic [3:0]       nib_s;
  logic             lz_s;
  logic             blank_s;

  assign tick_s     = (div_r == DIV_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);
  assign commit_s   = boundary_s && pend_r;

  // Divider, scan index, pending slot and display register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r  <= '0;
      idx_r  <= '0;
      disp_r <= 16'h0000;
      pval_r <= 16'h0000;
      pend_r <= 1'b0;
      ack_r  <= 1'b0;
      fd_r   <= 1'b0;
    end else begin
      div_r  <= tick_s ? '0 : div_r + DIV_W'(1);
      idx_r  <= tick_s ? idx_r + IDX_W'(1) : idx_r;
      fd_r   <= boundary_s;
      ack_r  <= commit_s;
      if (commit_s) begin
        disp_r <= pval_r;
      end
      // A load on the commit edge re-arms pending with the new value after the old one commits
      if (load) begin
        pval_r <= value;
        pend_r <= 1'b1;
      end else if (commit_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign nib_s = disp_r[{idx_r, 2'b00} +: 4];

  // Digit is a leading zero when it and every more significant nibble are zero
  always_comb begin
    lz_s = 1'b0;
    case (idx_r)
      2'd1:    lz_s = (disp_r[15:4]  == 12'h000);
      2'd2:    lz_s = (disp_r[15:8]  == 8'h00);
      2'd3:    lz_s = (disp_r[15:12] == 4'h0);
      default: lz_s = 1'b0;
    endcase
  end

  assign blank_s = BLANK_LZ && lz_s;

  hex_to_7seg u_dec (
    .nib   (nib_s),
    .blank (blank_s),
    .seg   (SevenSegout)
  );

  assign en         = ~(4'b0001 << idx_r);
  assign ack        = ack_r;
  assign pending    = pend_r;
  assign frame_done = fd_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized scoreboard bench for sevenseg_scan_ctrl (REFRESH_DIV = 4), with a
// second instance built without leading-zero blanking sharing the same stimulus.
module tb_sevenseg_scan_ctrl;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        ack1, pend1, fd1, ack0, pend0, fd0;
  logic [6:0]  seg1, seg0;
  logic [3:0]  en1, en0;

  int checks = 0;
  int errors = 0;

  // model state: cycles since reset, displayed value, pending slot
  int          m_n     = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_disp  = 16'h0000;
  logic [15:0] m_pval  = 16'h0000;
  bit          m_pend  = 1'b0;
  int          ack_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .ack(ack1), .pending(pend1), .frame_done(fd1), .SevenSegout(seg1), .en(en1)
  );

  sevenseg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .ack(ack0), .pending(pend0), .frame_done(fd0), .SevenSegout(seg0), .en(en0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t cycle=%0d: got %h expected %h", name, $time, m_n, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit blz);
    logic [15:0] sh;
    sh = v >> (4 * d);
    if (blz && d > 0 && sh == 16'h0000) return 7'h7F;
    return seg_tab[sh[3:0]];
  endfunction

  // monitor + reference model: check outputs of the current state, then
  // advance the model with the inputs about to be sampled at the next edge
  initial begin
    int  d;
    bit  exp_ack;
    bit  boundary;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        d       = (m_n / RD) % 4;
        exp_ack = (ack_q.size() > 0) && (ack_q[0] == m_n);
        chk("ack", {31'd0, ack1}, {31'd0, exp_ack});
        chk("ack_nolz", {31'd0, ack0}, {31'd0, exp_ack});
        if (exp_ack) void'(ack_q.pop_front());
        chk("pending", {31'd0, pend1}, {31'd0, m_pend});
        chk("frame_done", {31'd0, fd1}, {31'd0, (m_n > 0) && (m_n % FRAME == 0)});
        chk("en", {28'd0, en1}, {28'd0, 4'hF ^ (4'h1 << d)});
        chk("en_nolz", {28'd0, en0}, {28'd0, 4'hF ^ (4'h1 << d)});
        chk("seg", {25'd0, seg1}, {25'd0, exp_seg(m_disp, d, 1'b1)});
        chk("seg_nolz", {25'd0, seg0}, {25'd0, exp_seg(m_disp, d, 1'b0)});
      end
      if (rst) begin
        m_valid = 1'b1;
        m_n     = 0;
        m_disp  = 16'h0000;
        m_pval  = 16'h0000;
        m_pend  = 1'b0;
        ack_q.delete();
      end else if (m_valid) begin
        boundary = (m_n % FRAME) == (FRAME - 1);
        if (boundary && m_pend) begin
          m_disp = m_pval;
          ack_q.push_back(m_n + 1);
          m_pend = 1'b0;
        end
        if (load) begin
          m_pval = value;
          m_pend = 1'b1;
        end
        m_n++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < 64 && (m_n % FRAME) != p; k++) step();
    chk("wait_phase", m_n % FRAME, p);
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();

    do_load(16'h12AF);
    repeat (40) step();

    do_load(16'h0008);
    repeat (40) step();
    do_load(16'h0000);
    repeat (40) step();

    wait_phase(1);
    do_load(16'h1111);
    repeat (2) step();
    do_load(16'h2222);
    repeat (40) step();

    wait_phase(4);
    do_load(16'h1111);
    wait_phase(FRAME - 1);
    do_load(16'h3333);
    repeat (40) step();

    do_load(16'h5555);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 299);
      if (r < 30) begin
        do_load(16'($urandom));
      end else if (r == 299) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    repeat (40) step();
    chk("ack_queue_empty", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
